ip1_blob_packer: RTL and testbench
==================================

Name: ip1_blob_packer

Overview:
- Downstream neighbour of the ip1 fully-connected layer: consumes its 64-bit result stream (4 x 16-bit output channels per beat) and repacks it into 512-bit words (32 channels) for the next layer's 512-bit blob_din port.
- Includes a small output FIFO that decouples the two handshakes, optional ReLU on each lane, and zero-padding of a partial final word at end of frame.

Parameters:
- DW, 16, bits per channel value.
- DIN_W, 64, input beat width (DIN_W/DW = 4 lanes).
- DOUT_W, 512, output word width; RATIO = DOUT_W/DIN_W = 8 input beats per output word.
- FIFO_DEPTH, 2, output FIFO entries, each holding a DOUT_W word plus its eop flag.
- RELU, 0, when 1 each 16-bit lane is clamped: a negative value (MSB=1) becomes 0 before packing.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- blob_din_rdy  output  1  high when a beat can be accepted this cycle.
- blob_din_en  input  1  input beat valid.
- blob_din_eop  input  1  marks the last beat of a frame; qualified by blob_din_en.
- blob_din  input  DIN_W  input beat; lane 0 is bits [15:0].
- blob_dout_rdy  input  1  downstream can take a word this cycle.
- blob_dout_en  output  1  output word valid (transfer occurs this cycle).
- blob_dout_eop  output  1  last word of the frame; qualified by blob_dout_en.
- blob_dout  output  DOUT_W  packed output word.
- err_overflow  output  1  sticky flag: blob_din_en was seen while blob_din_rdy was low.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - Beat counter = 0, pack register = 0, FIFO empty, err_overflow = 0.
  - Outputs: blob_din_rdy=1 (once FIFO empty), blob_dout_en=0, blob_dout_eop=0, blob_dout=0.
  - Reset mid-frame discards any partial word and all FIFO contents.
- Input handshake:
  - blob_din_rdy = FIFO count < FIFO_DEPTH, combinational from registers only.
  - A beat is accepted when blob_din_en=1. If blob_din_rdy=0 at that time, the beat is dropped and err_overflow is set; it stays set until rst.
- Packing:
  - Accepted beat k (beat counter 0..RATIO-1) is written, after optional ReLU, into pack bits [k*DIN_W +: DIN_W].
  - The first beat of a word lands in the LSBs.
- Word completion: occurs on an accepted beat with counter == RATIO-1 or blob_din_eop=1.
  - The completed word (including the current beat) is pushed to the FIFO with eop = blob_din_eop.
  - Unfilled upper beats of a partial eop word are zero.
  - The counter returns to 0 and the pack register clears for the next word.
  - eop on beat RATIO-1 produces a single push with eop=1, never an extra empty word.
- Output handshake:
  - blob_dout_en = FIFO non-empty AND blob_dout_rdy, combinational.
  - blob_dout and blob_dout_eop show the FIFO head (zero when empty). A pop occurs when blob_dout_en=1.
- Latency: completing beat accepted at edge t makes the word visible at the FIFO head in cycle t+1. blob_dout_en can rise in that same cycle.
- Simultaneous push and pop on a full FIFO is not possible, because rdy=0 blocks the push. Push and pop in the same cycle on a partial FIFO leaves the count unchanged.
- Order: FIFO order is strictly preserved. Word and frame boundaries are only reset by eop or rst.
- Arithmetic: no data arithmetic besides the ReLU mux; lane values are passed bit-exact.
- Reference frame: ip1 produces 64 channels = 16 beats, giving 2 output words with eop on the second.

Test Plan:
- Reset, then 16 beats of channel values 0..63 with eop on beat 16 and blob_dout_rdy=1:
  - exactly 2 words;
  - word0 [15:0]=0 … [511:496]=31;
  - word1 holds 32..63 with eop=1;
  - first blob_dout_en one cycle after beat 8.
- 3 beats with eop on beat 3: one word, bits [191:0] = data, [511:192] = 0, eop=1.
- blob_dout_rdy=0, send 16 beats:
  - blob_din_rdy drops after the second push, with FIFO count = 2;
  - raising blob_dout_rdy drains 2 words in consecutive cycles;
  - err_overflow stays 0.
- Drive blob_din_en while blob_din_rdy=0: err_overflow=1 and that beat is absent from the output.
- RELU=1 with lane values 0xFFFE, 0x0005, 0x8000, 0x7FFF: packed lanes are 0x0000, 0x0005, 0x0000, 0x7FFF.
- Assert rst after 5 beats of a frame, then send a fresh 8-beat frame without eop: one word containing only the new data, eop=0, no residue from the old beats.

Source files
------------

// File: rtl/ip1_blob_packer.sv
// Repacks the ip1 64-bit result stream into 512-bit blob words.
// Each word passes through a small output FIFO; optional per-lane ReLU; a partial eop word is zero-padded.

module ip1_blob_packer_lane #(
    parameter int DW   = 16,
    parameter int RELU = 0
) (
    input  logic [DW-1:0] i_v,
    output logic [DW-1:0] o_v
);
    assign o_v = (RELU != 0 && i_v[DW-1]) ? '0 : i_v;
endmodule

module ip1_blob_packer #(
    parameter int DW         = 16,
    parameter int DIN_W      = 64,
    parameter int DOUT_W     = 512,
    parameter int FIFO_DEPTH = 2,
    parameter int RELU       = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              blob_din_rdy,
    input  logic              blob_din_en,
    input  logic              blob_din_eop,
    input  logic [DIN_W-1:0]  blob_din,
    input  logic              blob_dout_rdy,
    output logic              blob_dout_en,
    output logic              blob_dout_eop,
    output logic [DOUT_W-1:0] blob_dout,
    output logic              err_overflow
);
    localparam int LANES = DIN_W / DW;
    localparam int RATIO = DOUT_W / DIN_W;
    localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW    = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

    typedef struct packed {
        logic              eop;
        logic [DOUT_W-1:0] data;
    } ent_t;

    logic [CW-1:0]     r_cnt;
    logic [DOUT_W-1:0] r_pack;
    ent_t              r_mem [FIFO_DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [NW-1:0]     r_count;
    logic              r_err;

    logic [DIN_W-1:0]  w_beat;
    logic [DOUT_W-1:0] w_word;
    logic              w_acc;
    logic              w_push;
    logic              w_pop;
    ent_t              w_head;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        ip1_blob_packer_lane #(.DW(DW), .RELU(RELU)) u_lane (
            .i_v (blob_din[l*DW +: DW]),
            .o_v (w_beat[l*DW +: DW])
        );
    end

    // The pack register is cleared after every word, so slots above the
    // current beat are already zero when a partial word is pushed.
    for (genvar b = 0; b < RATIO; b++) begin : g_slot
        assign w_word[b*DIN_W +: DIN_W] = (r_cnt == CW'(b)) ? w_beat : r_pack[b*DIN_W +: DIN_W];
    end

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign blob_din_rdy  = (r_count < NW'(FIFO_DEPTH));
    assign w_acc         = blob_din_en & blob_din_rdy;
    assign w_push        = w_acc & (blob_din_eop | (r_cnt == LAST));
    assign blob_dout_en  = (r_count != '0) & blob_dout_rdy;
    assign w_pop         = blob_dout_en;
    assign w_head        = r_mem[r_rptr];
    assign blob_dout     = (r_count != '0) ? w_head.data : '0;
    assign blob_dout_eop = (r_count != '0) ? w_head.eop : 1'b0;
    assign err_overflow  = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_pack  <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_acc) begin
                if (w_push) begin
                    r_cnt  <= '0;
                    r_pack <= '0;
                end else begin
                    r_cnt  <= r_cnt + CW'(1);
                    r_pack <= w_word;
                end
            end
            if (w_push) r_wptr <= f_inc(r_wptr);
            if (w_pop)  r_rptr <= f_inc(r_rptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + NW'(1);
                2'b01:   r_count <= r_count - NW'(1);
                default: r_count <= r_count;
            endcase
            if (blob_din_en && !blob_din_rdy) r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= '{eop: blob_din_eop, data: w_word};
    end
endmodule

// File: tb/tb_ip1_blob_packer.sv
// Bench for ip1_blob_packer: plain and ReLU instances share stimulus; a scoreboard
// per instance checks every output word in order.

module tb_ip1_blob_packer;
    logic         clk = 1'b0;
    logic         rst;
    logic         din_en, din_eop, dout_rdy;
    logic [63:0]  din;
    logic         rdy0, en0, eop0, err0;
    logic         rdy1, en1, eop1, err1;
    logic [511:0] dout0, dout1;

    typedef struct packed {
        logic         eop;
        logic [511:0] data;
    } wrd_t;

    typedef struct {
        logic [15:0] vin;
        logic [15:0] vout;
    } relu_vec_t;

    wrd_t         q0[$], q1[$];
    int           errors = 0, checks = 0, words0 = 0;
    logic [511:0] last0;
    logic         last_eop0;
    logic [511:0] m_p0, m_p1;
    int           m_cnt;

    always #5 clk = ~clk;

    ip1_blob_packer u_dut0 (
        .clk(clk), .rst(rst), .blob_din_rdy(rdy0), .blob_din_en(din_en), .blob_din_eop(din_eop),
        .blob_din(din), .blob_dout_rdy(dout_rdy), .blob_dout_en(en0), .blob_dout_eop(eop0),
        .blob_dout(dout0), .err_overflow(err0)
    );

    ip1_blob_packer #(.RELU(1)) u_dut1 (
        .clk(clk), .rst(rst), .blob_din_rdy(rdy1), .blob_din_en(din_en), .blob_din_eop(din_eop),
        .blob_din(din), .blob_dout_rdy(dout_rdy), .blob_dout_en(en1), .blob_dout_eop(eop1),
        .blob_dout(dout1), .err_overflow(err1)
    );

    task automatic chk(input string n, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", n, got, exp);
        end
    endtask

    task automatic chk1(input string n, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0b expected=%0b", n, got, exp);
        end
    endtask

    function automatic logic [63:0] relu64(input logic [63:0] d);
        logic [63:0] r;
        r = d;
        for (int l = 0; l < 4; l++) if (d[16*l+15]) r[16*l +: 16] = '0;
        return r;
    endfunction

    always @(negedge clk) begin : mon
        wrd_t w;
        if (!rst) begin
            if (en0) begin
                words0++;
                last0     = dout0;
                last_eop0 = eop0;
                if (q0.size() == 0) chk1("dut0_spurious_word", 1'b1, 1'b0);
                else begin
                    w = q0.pop_front();
                    chk("dut0_word", dout0, w.data);
                    chk1("dut0_eop", eop0, w.eop);
                end
            end
            if (en1) begin
                if (q1.size() == 0) chk1("dut1_spurious_word", 1'b1, 1'b0);
                else begin
                    w = q1.pop_front();
                    chk("dut1_word", dout1, w.data);
                    chk1("dut1_eop", eop1, w.eop);
                end
            end
        end
    end

    task automatic model_clear();
        q0.delete();
        q1.delete();
        m_p0  = '0;
        m_p1  = '0;
        m_cnt = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        din_en  = 1'b0;
        din_eop = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    // acc: whether this beat must be accepted (rdy high) given the traffic so far
    task automatic send_beat(input logic [63:0] d, input logic e, input logic acc);
        din     = d;
        din_en  = 1'b1;
        din_eop = e;
        chk1("din_rdy", rdy0, acc);
        if (acc) begin
            m_p0[m_cnt*64 +: 64] = d;
            m_p1[m_cnt*64 +: 64] = relu64(d);
            if (m_cnt == 7 || e) begin
                q0.push_back(wrd_t'{eop: e, data: m_p0});
                q1.push_back(wrd_t'{eop: e, data: m_p1});
                m_p0  = '0;
                m_p1  = '0;
                m_cnt = 0;
            end else m_cnt++;
        end
        @(posedge clk);
        #1;
        din_en  = 1'b0;
        din_eop = 1'b0;
    endtask

    initial begin
        relu_vec_t    rt[8];
        logic [63:0]  d, ra, rb;
        logic [191:0] part;
        int           w_start;

        rt[0] = '{16'hFFFE, 16'h0000};
        rt[1] = '{16'h0005, 16'h0005};
        rt[2] = '{16'h8000, 16'h0000};
        rt[3] = '{16'h7FFF, 16'h7FFF};
        rt[4] = '{16'h0000, 16'h0000};
        rt[5] = '{16'h0001, 16'h0001};
        rt[6] = '{16'hFFFF, 16'h0000};
        rt[7] = '{16'h1234, 16'h1234};

        rst      = 1'b1;
        din_en   = 1'b0;
        din_eop  = 1'b0;
        din      = '0;
        dout_rdy = 1'b1;
        model_clear();
        idle(2);
        rst = 1'b0;
        #1;

        chk1("reset_din_rdy", rdy0, 1'b1);
        chk1("reset_dout_en", en0, 1'b0);
        chk1("reset_dout_eop", eop0, 1'b0);
        chk("reset_dout", dout0, '0);
        chk1("reset_err", err0, 1'b0);

        // reference frame: 64 channels in 16 beats
        w_start = words0;
        for (int b = 0; b < 16; b++) begin
            for (int l = 0; l < 4; l++) d[16*l +: 16] = 16'(4*b + l);
            send_beat(d, b == 15, 1'b1);
            if (b == 6) chk1("dout_en_before_beat8", en0, 1'b0);
            if (b == 7) chk1("dout_en_after_beat8", en0, 1'b1);
        end
        idle(3);
        chk("ref_word_count", 512'(words0 - w_start), 512'(2));
        chk("ref_last_lane31", 512'(last0[511:496]), 512'(63));
        chk1("ref_last_eop", last_eop0, 1'b1);

        // 3-beat partial frame
        w_start = words0;
        for (int b = 0; b < 3; b++) begin
            d = {$urandom, $urandom};
            part[b*64 +: 64] = d;
            send_beat(d, b == 2, 1'b1);
        end
        idle(3);
        chk("partial_count", 512'(words0 - w_start), 512'(1));
        chk("partial_low", 512'(last0[191:0]), 512'(part));
        chk("partial_upper", 512'(last0[511:192]), '0);
        chk1("partial_eop", last_eop0, 1'b1);

        // backpressure: fill the FIFO, then drop one beat
        dout_rdy = 1'b0;
        for (int b = 0; b < 16; b++) begin
            send_beat({$urandom, $urandom}, b == 15, 1'b1);
            if (b == 7) chk1("bp_rdy_after_first_push", rdy0, 1'b1);
        end
        chk1("bp_rdy_full", rdy0, 1'b0);
        chk1("bp_err_still_clear", err0, 1'b0);
        send_beat(64'hDEAD_BEEF_0BAD_F00D, 1'b0, 1'b0);
        chk1("overflow_err", err0, 1'b1);
        chk1("overflow_err_relu", err1, 1'b1);
        dout_rdy = 1'b1;
        @(negedge clk);
        chk1("drain0_en", en0, 1'b1);
        chk1("drain0_eop", eop0, 1'b0);
        @(negedge clk);
        chk1("drain1_en", en0, 1'b1);
        chk1("drain1_eop", eop0, 1'b1);
        @(negedge clk);
        chk1("drain_done", en0, 1'b0);
        idle(1);
        chk1("drain_rdy", rdy0, 1'b1);
        chk1("err_sticky", err0, 1'b1);
        // a dropped beat left in the pack register would show up in this word
        send_beat(64'h0123_4567_89AB_CDEF, 1'b1, 1'b1);
        idle(3);

        // ReLU table
        for (int l = 0; l < 4; l++) begin
            ra[16*l +: 16] = rt[l].vin;
            rb[16*l +: 16] = rt[4+l].vin;
        end
        send_beat(ra, 1'b0, 1'b1);
        send_beat(rb, 1'b1, 1'b1);
        @(negedge clk);
        chk1("relu_en", en1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("relu_lane%0d", i), 512'(dout1[16*i +: 16]), 512'(rt[i].vout));
            chk($sformatf("plain_lane%0d", i), 512'(dout0[16*i +: 16]), 512'(rt[i].vin));
        end
        idle(2);

        // reset mid-frame, then a fresh full word without eop
        for (int b = 0; b < 5; b++) send_beat({$urandom, $urandom}, 1'b0, 1'b1);
        do_reset();
        chk1("midreset_err", err0, 1'b0);
        chk1("midreset_dout_en", en0, 1'b0);
        w_start = words0;
        for (int b = 0; b < 8; b++) send_beat({$urandom, $urandom}, 1'b0, 1'b1);
        idle(3);
        chk("fresh_count", 512'(words0 - w_start), 512'(1));
        chk1("fresh_eop", last_eop0, 1'b0);

        chk("q0_empty", 512'(q0.size()), '0);
        chk("q1_empty", 512'(q1.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
